// File: rtl/xbar_arbiter_if.sv
// Handshake bundle between packet sources, downstream outputs and xbar_arbiter.
// The slave modport is the arbiter's view; master is the source/sink side.
interface xbar_arbiter_if #(
   parameter int unsigned NUM_INPUT  = 4,
   parameter int unsigned NUM_OUTPUT = 4
);
   localparam int unsigned IW = $clog2(NUM_INPUT);
   localparam int unsigned OW = $clog2(NUM_OUTPUT);

   logic [NUM_INPUT-1:0]       req_valid_i;
   logic [NUM_INPUT*OW-1:0]    req_dest_i;
   logic [NUM_INPUT-1:0]       req_last_i;
   logic [NUM_INPUT-1:0]       req_ready_o;
   logic [NUM_OUTPUT*IW-1:0]   select_vector_o;
   logic [NUM_OUTPUT-1:0]      out_valid_o;
   logic [NUM_OUTPUT-1:0]      out_ready_i;
   logic [NUM_OUTPUT-1:0]      timeout_o;

   modport slave (
      input  req_valid_i, req_dest_i, req_last_i, out_ready_i,
      output req_ready_o, select_vector_o, out_valid_o, timeout_o
   );

   modport master (
      output req_valid_i, req_dest_i, req_last_i, out_ready_i,
      input  req_ready_o, select_vector_o, out_valid_o, timeout_o
   );
endinterface

// File: rtl/xbar_arbiter.sv
// Per-output round-robin packet arbiter; grants are held for a whole packet.
// Optional stall timeout is enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_arbiter #(
   parameter int unsigned NUM_INPUT      = 4,
   parameter int unsigned NUM_OUTPUT     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic           clk_i,
   input logic           rst_i,
   xbar_arbiter_if.slave bus
);
   localparam int unsigned IW = $clog2(NUM_INPUT);
   localparam int unsigned OW = $clog2(NUM_OUTPUT);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e          state_q [NUM_OUTPUT];
   state_e          state_d [NUM_OUTPUT];
   logic [IW-1:0]   owner_q [NUM_OUTPUT];
   logic [IW-1:0]   owner_d [NUM_OUTPUT];
   logic [IW-1:0]   ptr_q   [NUM_OUTPUT];
   logic [IW-1:0]   ptr_d   [NUM_OUTPUT];

   logic [OW-1:0]           dest [NUM_INPUT];
   logic [NUM_OUTPUT-1:0]   out_valid;
   logic [NUM_OUTPUT-1:0]   xfer;
   logic [NUM_OUTPUT-1:0]   found;
   logic [NUM_INPUT-1:0]    req_ready;
   logic [NUM_OUTPUT*IW-1:0] select;

`ifdef XBAR_ARB_TIMEOUT_EN
   localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0]         stall_q [NUM_OUTPUT];
   logic [SW-1:0]         stall_d [NUM_OUTPUT];
   logic [NUM_OUTPUT-1:0] timeout_q;
   logic [NUM_OUTPUT-1:0] timeout_d;
`endif

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int unsigned k);
      return IW'((32'(p) + k) % NUM_INPUT);
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < NUM_INPUT; i++) begin
         dest[i] = bus.req_dest_i[i*OW +: OW];
      end
   end

   // Beat handshake is combinational from the owner's request; suppressed in reset.
   always_comb begin
      out_valid = '0;
      xfer      = '0;
      req_ready = '0;
      for (int unsigned o = 0; o < NUM_OUTPUT; o++) begin
         if (state_q[o] == ST_BUSY && !rst_i) begin
            out_valid[o] = bus.req_valid_i[owner_q[o]] && (dest[owner_q[o]] == OW'(o));
            xfer[o]      = out_valid[o] && bus.out_ready_i[o];
            if (xfer[o]) begin
               req_ready[owner_q[o]] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      found = '0;
      for (int unsigned o = 0; o < NUM_OUTPUT; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
`ifdef XBAR_ARB_TIMEOUT_EN
         stall_d[o]   = stall_q[o];
         timeout_d[o] = 1'b0;
`endif
         if (state_q[o] == ST_IDLE) begin
            for (int unsigned k = 1; k <= NUM_INPUT; k++) begin
               if (!found[o] && bus.req_valid_i[wrap_idx(ptr_q[o], k)] &&
                   dest[wrap_idx(ptr_q[o], k)] == OW'(o)) begin
                  found[o]   = 1'b1;
                  owner_d[o] = wrap_idx(ptr_q[o], k);
                  state_d[o] = ST_BUSY;
`ifdef XBAR_ARB_TIMEOUT_EN
                  stall_d[o] = '0;
`endif
               end
            end
         end else if (xfer[o] && bus.req_last_i[owner_q[o]]) begin
            state_d[o] = ST_IDLE;
            ptr_d[o]   = owner_q[o];
`ifdef XBAR_ARB_TIMEOUT_EN
         end else if (xfer[o]) begin
            stall_d[o] = '0;
         end else if (stall_q[o] == SW'(TIMEOUT_CYCLES - 1)) begin
            // Release happens on the edge that completes the TIMEOUT_CYCLES-th idle BUSY cycle.
            state_d[o]   = ST_IDLE;
            ptr_d[o]     = owner_q[o];
            timeout_d[o] = 1'b1;
         end else begin
            stall_d[o] = stall_q[o] + 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned o = 0; o < NUM_OUTPUT; o++) begin
            state_q[o] <= ST_IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= IW'(NUM_INPUT - 1);
`ifdef XBAR_ARB_TIMEOUT_EN
            stall_q[o] <= '0;
`endif
         end
`ifdef XBAR_ARB_TIMEOUT_EN
         timeout_q <= '0;
`endif
      end else begin
         for (int unsigned o = 0; o < NUM_OUTPUT; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
`ifdef XBAR_ARB_TIMEOUT_EN
            stall_q[o] <= stall_d[o];
`endif
         end
`ifdef XBAR_ARB_TIMEOUT_EN
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      select = '0;
      for (int unsigned o = 0; o < NUM_OUTPUT; o++) begin
         select[o*IW +: IW] = owner_q[o];
      end
   end

   assign bus.select_vector_o = select;
   assign bus.out_valid_o     = out_valid;
   assign bus.req_ready_o     = req_ready;
`ifdef XBAR_ARB_TIMEOUT_EN
   assign bus.timeout_o = timeout_q;
`else
   assign bus.timeout_o = '0;
`endif
endmodule

// File: tb/tb_xbar_arbiter.sv
// Directed self-checking bench for xbar_arbiter (4 sources, 4 outputs, TIMEOUT_CYCLES=8).
module tb_xbar_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_n  = 0;
   int   total_n = 0;

   xbar_arbiter_if #(.NUM_INPUT(4), .NUM_OUTPUT(4)) bus ();

   xbar_arbiter #(.NUM_INPUT(4), .NUM_OUTPUT(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [1:0] d, input logic l);
      bus.req_valid_i[i]         = v;
      bus.req_dest_i[i*2 +: 2]   = d;
      bus.req_last_i[i]          = l;
   endtask

   function automatic logic [1:0] sel_f(input int o);
      return bus.select_vector_o[o*2 +: 2];
   endfunction

   task automatic clear_inputs();
      bus.req_valid_i = '0;
      bus.req_dest_i  = '0;
      bus.req_last_i  = '0;
      bus.out_ready_i = '1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      set_src(0, 1'b1, 2'd0, 1'b1);
      tick();
      tick();
      #1;
      total_n++; if (bus.req_ready_o !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", bus.req_ready_o); else pass_n++;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", bus.out_valid_o); else pass_n++;
      total_n++; if (bus.timeout_o !== 4'b0000) $display("FAIL rst_timeout: got %b want 0000", bus.timeout_o); else pass_n++;
      total_n++; if (bus.select_vector_o !== 8'h00) $display("FAIL rst_select: got %h want 00", bus.select_vector_o); else pass_n++;
      clear_inputs();
      rst = 1'b0;
   endtask

   task automatic test_single_packet();
      do_reset();
      set_src(0, 1'b1, 2'd2, 1'b0);
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL sp_arb_valid: got %b want 0000", bus.out_valid_o); else pass_n++;
      for (int b = 1; b <= 3; b++) begin
         tick();
         set_src(0, 1'b1, 2'd2, (b == 3));
         #1;
         total_n++; if (bus.out_valid_o !== 4'b0100) $display("FAIL sp_valid_b%0d: got %b want 0100", b, bus.out_valid_o); else pass_n++;
         total_n++; if (bus.req_ready_o !== 4'b0001) $display("FAIL sp_ready_b%0d: got %b want 0001", b, bus.req_ready_o); else pass_n++;
         total_n++; if (sel_f(2) !== 2'd0) $display("FAIL sp_sel_b%0d: got %0d want 0", b, sel_f(2)); else pass_n++;
      end
      tick();
      set_src(0, 1'b1, 2'd2, 1'b0);
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL sp_idle_valid: got %b want 0000", bus.out_valid_o); else pass_n++;
      total_n++; if (bus.req_ready_o !== 4'b0000) $display("FAIL sp_idle_ready: got %b want 0000", bus.req_ready_o); else pass_n++;
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_src [5];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      for (int i = 0; i < 4; i++) set_src(i, 1'b1, 2'd1, 1'b1);
      #1;
      for (int g = 0; g < 5; g++) begin
         total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL rr_idle_g%0d: got %b want 0000", g, bus.out_valid_o); else pass_n++;
         tick();
         #1;
         total_n++; if (sel_f(1) !== exp_src[g]) $display("FAIL rr_sel_g%0d: got %0d want %0d", g, sel_f(1), exp_src[g]); else pass_n++;
         total_n++; if (bus.req_ready_o !== (4'b0001 << exp_src[g])) $display("FAIL rr_ready_g%0d: got %b want %b", g, bus.req_ready_o, 4'b0001 << exp_src[g]); else pass_n++;
         tick();
         #1;
      end
      clear_inputs();
   endtask

   task automatic test_parallel();
      do_reset();
      set_src(0, 1'b1, 2'd0, 1'b0);
      set_src(1, 1'b1, 2'd3, 1'b0);
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL par_arb: got %b want 0000", bus.out_valid_o); else pass_n++;
      for (int b = 1; b <= 2; b++) begin
         tick();
         set_src(0, 1'b1, 2'd0, (b == 2));
         set_src(1, 1'b1, 2'd3, (b == 2));
         #1;
         total_n++; if (bus.out_valid_o !== 4'b1001) $display("FAIL par_valid_b%0d: got %b want 1001", b, bus.out_valid_o); else pass_n++;
         total_n++; if (bus.req_ready_o !== 4'b0011) $display("FAIL par_ready_b%0d: got %b want 0011", b, bus.req_ready_o); else pass_n++;
         total_n++; if (bus.select_vector_o !== 8'b01_00_00_00) $display("FAIL par_sel_b%0d: got %b want 01000000", b, bus.select_vector_o); else pass_n++;
      end
      tick();
      clear_inputs();
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL par_end: got %b want 0000", bus.out_valid_o); else pass_n++;
   endtask

   task automatic test_backpressure();
      do_reset();
      set_src(2, 1'b1, 2'd1, 1'b0);
      tick();
      bus.out_ready_i = 4'b1101;
      set_src(3, 1'b1, 2'd1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         total_n++; if (bus.out_valid_o !== 4'b0010) $display("FAIL bp_valid_c%0d: got %b want 0010", c, bus.out_valid_o); else pass_n++;
         total_n++; if (bus.req_ready_o !== 4'b0000) $display("FAIL bp_ready_c%0d: got %b want 0000", c, bus.req_ready_o); else pass_n++;
         total_n++; if (sel_f(1) !== 2'd2) $display("FAIL bp_sel_c%0d: got %0d want 2", c, sel_f(1)); else pass_n++;
         tick();
      end
      bus.out_ready_i = 4'b1111;
      set_src(2, 1'b1, 2'd1, 1'b1);
      #1;
      total_n++; if (bus.req_ready_o !== 4'b0100) $display("FAIL bp_release: got %b want 0100", bus.req_ready_o); else pass_n++;
      tick();
      set_src(2, 1'b0, 2'd1, 1'b0);
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL bp_bubble: got %b want 0000", bus.out_valid_o); else pass_n++;
      tick();
      #1;
      total_n++; if (sel_f(1) !== 2'd3) $display("FAIL bp_next_sel: got %0d want 3", sel_f(1)); else pass_n++;
      total_n++; if (bus.req_ready_o !== 4'b1000) $display("FAIL bp_next_ready: got %b want 1000", bus.req_ready_o); else pass_n++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      set_src(1, 1'b1, 2'd0, 1'b1);
      tick();
      tick();
      set_src(1, 1'b0, 2'd0, 1'b0);
      set_src(2, 1'b1, 2'd0, 1'b0);
      tick();
      #1;
      total_n++; if (bus.req_ready_o !== 4'b0100) $display("FAIL rm_beat1: got %b want 0100", bus.req_ready_o); else pass_n++;
      tick();
      rst = 1'b1;
      set_src(0, 1'b1, 2'd0, 1'b1);
      #1;
      total_n++; if (bus.req_ready_o !== 4'b0000) $display("FAIL rm_rst_ready: got %b want 0000", bus.req_ready_o); else pass_n++;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL rm_rst_valid: got %b want 0000", bus.out_valid_o); else pass_n++;
      tick();
      rst = 1'b0;
      #1;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL rm_idle: got %b want 0000", bus.out_valid_o); else pass_n++;
      tick();
      #1;
      total_n++; if (sel_f(0) !== 2'd0) $display("FAIL rm_winner_sel: got %0d want 0", sel_f(0)); else pass_n++;
      total_n++; if (bus.req_ready_o !== 4'b0001) $display("FAIL rm_winner_ready: got %b want 0001", bus.req_ready_o); else pass_n++;
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      set_src(1, 1'b1, 2'd2, 1'b0);
      tick();
      set_src(1, 1'b0, 2'd2, 1'b0);
      set_src(3, 1'b1, 2'd2, 1'b1);
      for (int c = 1; c <= 8; c++) begin
         #1;
         total_n++; if (bus.timeout_o !== 4'b0000) $display("FAIL to_wait_c%0d: got %b want 0000", c, bus.timeout_o); else pass_n++;
         total_n++; if (sel_f(2) !== 2'd1) $display("FAIL to_owner_c%0d: got %0d want 1", c, sel_f(2)); else pass_n++;
         tick();
      end
      #1;
`ifdef XBAR_ARB_TIMEOUT_EN
      total_n++; if (bus.timeout_o !== 4'b0100) $display("FAIL to_pulse: got %b want 0100", bus.timeout_o); else pass_n++;
      total_n++; if (bus.out_valid_o !== 4'b0000) $display("FAIL to_idle: got %b want 0000", bus.out_valid_o); else pass_n++;
      tick();
      #1;
      total_n++; if (bus.timeout_o !== 4'b0000) $display("FAIL to_pulse_end: got %b want 0000", bus.timeout_o); else pass_n++;
      total_n++; if (sel_f(2) !== 2'd3) $display("FAIL to_next_sel: got %0d want 3", sel_f(2)); else pass_n++;
      total_n++; if (bus.req_ready_o !== 4'b1000) $display("FAIL to_next_ready: got %b want 1000", bus.req_ready_o); else pass_n++;
`else
      for (int c = 0; c < 4; c++) begin
         total_n++; if (bus.timeout_o !== 4'b0000) $display("FAIL nto_pulse_c%0d: got %b want 0000", c, bus.timeout_o); else pass_n++;
         total_n++; if (sel_f(2) !== 2'd1) $display("FAIL nto_owner_c%0d: got %0d want 1", c, sel_f(2)); else pass_n++;
         total_n++; if (bus.req_ready_o !== 4'b0000) $display("FAIL nto_ready_c%0d: got %b want 0000", c, bus.req_ready_o); else pass_n++;
         tick();
         #1;
      end
`endif
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_parallel();
      test_backpressure();
      test_reset_mid_packet();
      test_timeout();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/xbar_arbiter.md
Name: xbar_arbiter

Overview:
- Per-output round-robin packet arbiter that sequences the shared xbar: collects requests from NUM_INPUT sources, each naming one destination output.
- Drives the xbar select vector and per-output valid/ready handshakes.
- Locks a grant for a whole multi-beat packet, so beats of different sources never interleave on one output.

Parameters:
- NUM_INPUT, 4, number of requesting sources (>=2).
- NUM_OUTPUT, 4, number of xbar outputs (>=2).
- TIMEOUT_CYCLES, 64, stall limit in cycles, used only with XBAR_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_INPUT  source i has a beat pending.
- req_dest_i  in  NUM_INPUT*$clog2(NUM_OUTPUT)  destination of source i.
- req_last_i  in  NUM_INPUT  beat is last of packet.
- req_ready_o  out  NUM_INPUT  beat of source i accepted this cycle.
- select_vector_o  out  NUM_OUTPUT*$clog2(NUM_INPUT)  xbar select; field o = source routed to output o.
- out_valid_o  out  NUM_OUTPUT  output o carries a valid beat.
- out_ready_i  in  NUM_OUTPUT  downstream of output o accepts.
- timeout_o  out  NUM_OUTPUT  one-cycle pulse on forced release.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Each output o holds the following state:
  - state: IDLE or BUSY.
  - owner_q: $clog2(NUM_INPUT) bits.
  - ptr_q: last granted source.
- Reset values: state=IDLE, owner_q=0, ptr_q=NUM_INPUT-1, so the first search starts at source 0. All outputs reset to 0: req_ready_o, out_valid_o, timeout_o, and select_vector_o.
- Reset asserted mid-packet: all outputs go IDLE at that edge. The packet is abandoned; no ready is asserted while rst_i is high.
- A request of source i targets output o when req_valid_i[i] && req_dest_i[i]==o.
- IDLE, output o:
  - out_valid_o[o]=0.
  - select field holds owner_q.
  - Candidates are searched from (ptr_q+1) mod NUM_INPUT upward, wrapping.
  - The first targeting source s is registered: owner_q<=s, state<=BUSY.
  - No candidate: stay IDLE.
  - Grant latency is 1 cycle; no beat transfers in the arbitration cycle.
- BUSY, output o:
  - select field = owner_q.
  - out_valid_o[o] = req_valid_i[owner_q] && req_dest_i[owner_q]==o.
  - req_ready_o[owner_q] = out_ready_i[o] && out_valid_o[o].
  - A transfer is valid && ready. A transfer with req_last_i[owner_q]=1 sets state<=IDLE and ptr_q<=owner_q.
  - Next arbitration is the following cycle, giving a one-cycle bubble between packets.
- req_ready_o[i]=0 for every source not owning an output.
- A source can own at most one output, since its destination is unique.
- Source protocol:
  - dest must be stable from first valid until last beat accepted.
  - If dest changes mid-packet, out_valid_o[o] drops and the grant stays held (no ready). With the timeout feature, the grant is reclaimed.
- Valid deassertion by the owner inside a packet: output stays BUSY, out_valid_o=0, no grant lost.
- Single-beat packet (valid&&last): BUSY lasts 1 cycle if out_ready_i=1.
- Simultaneous requests for different outputs are arbitrated independently in the same cycle.
- Simultaneous requests for one output: exactly one granted. Fairness bound: a continuously requesting source is granted within NUM_INPUT arbitrations.
- Combinational paths: req_valid_i/req_dest_i/out_ready_i -> out_valid_o/req_ready_o are allowed. No combinational path to select_vector_o.

Optional Feature:
- XBAR_ARB_TIMEOUT_EN defined:
  - A per-output stall counter of $clog2(TIMEOUT_CYCLES+1) bits counts BUSY cycles without a transfer. It is cleared on any transfer and on entry to BUSY.
  - Reaching TIMEOUT_CYCLES forces state<=IDLE and ptr_q<=owner_q, and pulses timeout_o[o] for 1 cycle.
- Undefined: no counter logic; timeout_o tied 0; a BUSY output waits indefinitely.

Test Plan:
- Reset, then src0 dest=2, 3-beat packet, out_ready_i=all 1:
  - Cycle 1 arbitration: out_valid_o=0.
  - Cycles 2-4: select field2=0, out_valid_o[2]=1, req_ready_o[0]=1.
  - Cycle 5: IDLE.
- src0..3 all request dest=1 with single-beat packets, continuously: grants in order 0,1,2,3,0, one every 2 cycles; select field1 follows that order; no starvation.
- src0->out0 and src1->out3, both 2-beat, simultaneous: both granted same cycle, independent beats; req_ready_o=0b0011 during packet.
- src2 holds out1 and out_ready_i[1]=0 for 5 cycles: out_valid_o[1]=1 throughout, req_ready_o[2]=0, no other source granted out1 even if requesting.
- rst_i pulsed mid-packet (beat 2 of 4): next cycle all outputs IDLE, ptr reset, src0 wins next arbitration regardless of prior owner.
- With XBAR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: owner drops valid without last for 8 cycles -> timeout_o[o]=1 for one cycle, output IDLE, a waiting src granted next cycle. Without the macro, timeout_o stays 0 and the output stays BUSY.
